// File: rtl/fm_tile_buffer_if.sv
// Load-stream and tile-read bus of the feature-map tile buffer.
// slave  : the buffer itself
// master : loader + compute-array side that drives requests and takes beats
interface fm_tile_buffer_if #(
  parameter int N_p = 4,
  parameter int R_p = 16,
  parameter int C_p = 16,
  parameter int W_p = 32
);
  // load stream
  logic                   wr_v_i;
  logic [W_p-1:0]         wr_data_i;
  logic                   wr_ready_o;
  // tile request
  logic                   rd_req_v_i;
  logic [$clog2(R_p)-1:0] rd_row_i;
  logic [$clog2(C_p)-1:0] rd_col_i;
  logic                   rd_req_ready_o;
  // tile beats
  logic                   rd_v_o;
  logic [N_p*W_p-1:0]     rd_data_o;
  logic                   rd_last_o;
  logic                   rd_yumi_i;
  // bank control / status
  logic                   release_i;
  logic [1:0]             bank_full_o;

  modport slave (
    input  wr_v_i, wr_data_i, rd_req_v_i, rd_row_i, rd_col_i, rd_yumi_i, release_i,
    output wr_ready_o, rd_req_ready_o, rd_v_o, rd_data_o, rd_last_o, bank_full_o
  );

  modport master (
    output wr_v_i, wr_data_i, rd_req_v_i, rd_row_i, rd_col_i, rd_yumi_i, release_i,
    input  wr_ready_o, rd_req_ready_o, rd_v_o, rd_data_o, rd_last_o, bank_full_o
  );
endinterface

// File: rtl/fm_tile_buffer.sv
// Double-buffered input feature-map buffer. A loader streams N_p x R_p x C_p
// words (channel-major, column fastest) into one bank while the compute array
// reads TR_p x TC_p tiles from the other, one pixel (all channels) per beat.
// Pixels outside the map read as zero. Read path: issue -> RAM register ->
// output register, with backpressure handled by the valid bits of each stage.
module fm_tile_buffer #(
  parameter int N_p  = 4,
  parameter int R_p  = 16,
  parameter int C_p  = 16,
  parameter int W_p  = 32,
  parameter int TR_p = 4,
  parameter int TC_p = 4
) (
  input logic            clk_i,
  input logic            reset_n_i,
  fm_tile_buffer_if.slave bus
);

  localparam int RW    = $clog2(R_p);
  localparam int CW    = $clog2(C_p);
  localparam int CHW   = (N_p  > 1) ? $clog2(N_p)  : 1;
  localparam int TRW   = (TR_p > 1) ? $clog2(TR_p) : 1;
  localparam int TCW   = (TC_p > 1) ? $clog2(TC_p) : 1;
  // one address space per lane: {bank, row, col}
  localparam int AW    = 1 + RW + CW;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE,   // waiting for a request on a full bank
    RUN,    // issuing tile pixel reads
    DRAIN   // all pixels issued, waiting for the last beat to be taken
  } rd_state_t;

  // ---------------------------------------------------------------- state
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     full;
  logic [1:0]     full_next;

  logic [CHW-1:0] wr_ch;
  logic [RW-1:0]  wr_row;
  logic [CW-1:0]  wr_col;

  rd_state_t      state;
  logic [RW-1:0]  org_row;
  logic [CW-1:0]  org_col;
  logic [TRW-1:0] tile_r;
  logic [TCW-1:0] tile_c;

  logic           s1_v;
  logic           s1_zero;
  logic           s1_last;

  logic               rd_v;
  logic               rd_last;
  logic [N_p*W_p-1:0] rd_data;

  // ---------------------------------------------------------------- control
  logic               wr_fire;
  logic               wr_done;
  logic               req_fire;
  logic               rel_fire;
  logic               issue;
  logic               s1_adv;
  logic               beat_fire;
  logic               tile_end;
  logic               pix_in;
  logic [RW:0]        pix_row;
  logic [CW:0]        pix_col;
  logic               ram_en;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic [N_p*W_p-1:0] ram_word;

  assign wr_fire = bus.wr_v_i && !full[wr_ptr];
  assign wr_done = wr_fire
                && (wr_ch  == CHW'(N_p - 1))
                && (wr_row == RW'(R_p - 1))
                && (wr_col == CW'(C_p - 1));

  assign req_fire = bus.rd_req_v_i && (state == IDLE) && full[rd_ptr];
  // a request accepted in the same cycle keeps the bank; the release is dropped
  assign rel_fire = bus.release_i && (state == IDLE) && full[rd_ptr] && !req_fire;

  // origin + offset is one bit wider so off-map pixels never wrap back in range
  assign pix_row  = {1'b0, org_row} + (RW+1)'(tile_r);
  assign pix_col  = {1'b0, org_col} + (CW+1)'(tile_c);
  assign pix_in   = (pix_row < (RW+1)'(R_p)) && (pix_col < (CW+1)'(C_p));
  assign tile_end = (tile_r == TRW'(TR_p - 1)) && (tile_c == TCW'(TC_p - 1));

  assign beat_fire = rd_v && bus.rd_yumi_i;
  assign s1_adv    = s1_v && (!rd_v || bus.rd_yumi_i);
  assign issue     = (state == RUN) && (!s1_v || s1_adv);
  // padded pixels skip the RAM; the RAM register keeps its old value
  assign ram_en    = issue && pix_in;

  assign wr_addr = {wr_ptr, wr_row, wr_col};
  assign rd_addr = {rd_ptr, pix_row[RW-1:0], pix_col[CW-1:0]};

  assign bus.wr_ready_o     = !full[wr_ptr];
  assign bus.rd_req_ready_o = (state == IDLE) && full[rd_ptr];
  assign bus.rd_v_o         = rd_v;
  assign bus.rd_last_o      = rd_last;
  assign bus.rd_data_o      = rd_data;
  assign bus.bank_full_o    = full;

  // completion and release always hit different banks, so both apply
  always_comb begin
    full_next = full;
    if (wr_done)  full_next[wr_ptr] = 1'b1;
    if (rel_fire) full_next[rd_ptr] = 1'b0;
  end

  // ---------------------------------------------------------------- storage
  // one RAM per channel so a beat reads every channel in parallel
  for (genvar gi = 0; gi < N_p; gi++) begin : g_lane
    logic [W_p-1:0] mem [DEPTH];
    logic [W_p-1:0] q;

    // lane RAM: write the loader word for this channel, registered read
    always_ff @(posedge clk_i) begin
      if (wr_fire && (wr_ch == CHW'(gi))) mem[wr_addr] <= bus.wr_data_i;
      if (ram_en) q <= mem[rd_addr];
    end

    assign ram_word[gi*W_p +: W_p] = q;
  end

  // ---------------------------------------------------------------- write side
  // load counter: col fastest, then row, then channel; wraps to 0 on completion
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ch  <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else if (wr_fire) begin
      if (wr_col == CW'(C_p - 1)) begin
        wr_col <= '0;
        if (wr_row == RW'(R_p - 1)) begin
          wr_row <= '0;
          if (wr_ch == CHW'(N_p - 1)) wr_ch <= '0;
          else                        wr_ch <= wr_ch + 1'b1;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  // bank pointers and full flags
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      full   <= 2'b00;
    end else begin
      if (wr_done)  wr_ptr <= ~wr_ptr;
      if (rel_fire) rd_ptr <= ~rd_ptr;
      full <= full_next;
    end
  end

  // ---------------------------------------------------------------- read side
  // tile FSM: latch origin, walk pixels row-major, wait for the last beat
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      org_row <= '0;
      org_col <= '0;
      tile_r  <= '0;
      tile_c  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            org_row <= bus.rd_row_i;
            org_col <= bus.rd_col_i;
            tile_r  <= '0;
            tile_c  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (tile_end) begin
              state <= DRAIN;
            end else if (tile_c == TCW'(TC_p - 1)) begin
              tile_c <= '0;
              tile_r <= tile_r + 1'b1;
            end else begin
              tile_c <= tile_c + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat_fire && rd_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM-read stage: tracks the pixel whose data sits in the lane registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v    <= 1'b0;
      s1_zero <= 1'b0;
      s1_last <= 1'b0;
    end else if (issue) begin
      s1_v    <= 1'b1;
      s1_zero <= !pix_in;
      s1_last <= tile_end;
    end else if (s1_adv) begin
      s1_v    <= 1'b0;
    end
  end

  // output beat register: holds data/last stable until the consumer takes it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      rd_data <= '0;
    end else if (s1_adv) begin
      rd_v    <= 1'b1;
      rd_last <= s1_last;
      rd_data <= s1_zero ? '0 : ram_word;
    end else if (beat_fire) begin
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_tile_buffer.sv
// Directed bench for fm_tile_buffer: a map-level model (bank arrays + expected
// beat queue) is checked against the DUT on every falling edge, and literal
// pixel values pin the model.
module tb_fm_tile_buffer;

  localparam int N  = 4;
  localparam int R  = 16;
  localparam int C  = 16;
  localparam int W  = 32;
  localparam int TR = 4;
  localparam int TC = 4;
  localparam int NB = TR * TC;
  localparam int RW = $clog2(R);
  localparam int CW = $clog2(C);

  typedef logic [N*W-1:0] wide_t;
  typedef struct {
    wide_t data;
    logic  last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fm_tile_buffer_if #(.N_p(N), .R_p(R), .C_p(C), .W_p(W)) bus ();

  fm_tile_buffer #(
    .N_p(N), .R_p(R), .C_p(C), .W_p(W), .TR_p(TR), .TC_p(TC)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  logic [W-1:0] mem_m [2][N][R][C];
  bit           m_wr_ptr;
  bit           m_rd_ptr;
  logic [1:0]   m_full;
  int           w_ch, w_row, w_col;
  bit           m_busy;
  beat_t        exp_q [$];
  int           tile_beats;
  wide_t        cap [NB];
  bit           stall_prev;
  wide_t        prev_data;
  logic         prev_last;
  bit           first_wait;
  int           wait_cnt;

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // per-cycle model update and comparison, sampled on the falling edge
  task automatic monitor();
    bit    acc, rel, wr, busy0;
    wide_t d;
    int    r, c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rd_v",      wide_t'(bus.rd_v_o), '0);
        chk("rst_rd_last",   wide_t'(bus.rd_last_o), '0);
        chk("rst_rd_data",   bus.rd_data_o, '0);
        chk("rst_bank_full", wide_t'(bus.bank_full_o), '0);
        chk("rst_wr_ready",  wide_t'(bus.wr_ready_o), wide_t'(1));
        chk("rst_req_ready", wide_t'(bus.rd_req_ready_o), '0);
        m_full = 2'b00; m_wr_ptr = 1'b0; m_rd_ptr = 1'b0;
        w_ch = 0; w_row = 0; w_col = 0;
        m_busy = 1'b0; exp_q.delete(); stall_prev = 1'b0; first_wait = 1'b0;
      end else begin
        busy0 = m_busy;
        acc = bus.rd_req_v_i && !busy0 && m_full[m_rd_ptr];
        rel = bus.release_i && !busy0 && m_full[m_rd_ptr] && !acc;
        wr  = bus.wr_v_i && !m_full[m_wr_ptr];

        chk("bank_full", wide_t'(bus.bank_full_o), wide_t'(m_full));
        chk("wr_ready",  wide_t'(bus.wr_ready_o), wide_t'(!m_full[m_wr_ptr]));
        chk("req_ready", wide_t'(bus.rd_req_ready_o), wide_t'(!busy0 && m_full[m_rd_ptr]));

        if (first_wait) begin
          wait_cnt++;
          if (wait_cnt < 3) begin
            chk("first_beat_early", wide_t'(bus.rd_v_o), '0);
          end else begin
            chk("first_beat_latency", wide_t'(bus.rd_v_o), wide_t'(1));
            first_wait = 1'b0;
          end
        end

        if (bus.rd_v_o) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", wide_t'(bus.rd_v_o), '0);
          end else begin
            chk("beat_data", bus.rd_data_o, exp_q[0].data);
            chk("beat_last", wide_t'(bus.rd_last_o), wide_t'(exp_q[0].last));
          end
          if (stall_prev) begin
            chk("stall_data_hold", bus.rd_data_o, prev_data);
            chk("stall_last_hold", wide_t'(bus.rd_last_o), wide_t'(prev_last));
          end
          if (bus.rd_yumi_i) begin
            if (tile_beats < NB) cap[tile_beats] = bus.rd_data_o;
            tile_beats++;
            if (exp_q.size() > 0) begin
              if (exp_q[0].last) m_busy = 1'b0;
              void'(exp_q.pop_front());
            end
          end
        end
        stall_prev = bus.rd_v_o && !bus.rd_yumi_i;
        prev_data  = bus.rd_data_o;
        prev_last  = bus.rd_last_o;

        if (acc) begin
          for (int tr = 0; tr < TR; tr++) begin
            for (int tc = 0; tc < TC; tc++) begin
              r = int'(bus.rd_row_i) + tr;
              c = int'(bus.rd_col_i) + tc;
              d = '0;
              for (int n = 0; n < N; n++)
                if (r < R && c < C) d[n*W +: W] = mem_m[m_rd_ptr][n][r][c];
              exp_q.push_back('{data: d, last: (tr == TR-1 && tc == TC-1)});
            end
          end
          m_busy = 1'b1; tile_beats = 0; first_wait = 1'b1; wait_cnt = 0;
        end

        if (wr) begin
          mem_m[m_wr_ptr][w_ch][w_row][w_col] = bus.wr_data_i;
          w_col++;
          if (w_col == C) begin
            w_col = 0; w_row++;
            if (w_row == R) begin
              w_row = 0; w_ch++;
              if (w_ch == N) begin
                w_ch = 0;
                m_full[m_wr_ptr] = 1'b1;
                m_wr_ptr = ~m_wr_ptr;
              end
            end
          end
        end

        if (rel) begin
          m_full[m_rd_ptr] = 1'b0;
          m_rd_ptr = ~m_rd_ptr;
        end
      end
    end
  endtask

  task automatic load_bank(input int base);
    int  guard;
    bit  took;
    for (int k = 0; k < N*R*C; k++) begin
      bus.wr_v_i    = 1'b1;
      bus.wr_data_i = W'(base + k);
      guard = 0;
      took  = 1'b0;
      while (!took) begin
        took = bus.wr_ready_o;
        @(posedge clk); #1;
        guard++;
        if (!took && guard > 20) begin
          fail_msg("load_timeout");
          bus.wr_v_i = 1'b0;
          return;
        end
      end
    end
    bus.wr_v_i = 1'b0;
  endtask

  // request a tile and consume it; alt = yumi every other cycle,
  // rel_at >= 0 pulses release_i that many cycles after acceptance
  task automatic run_tile(input int row, input int col, input bit alt, input int rel_at);
    int guard;
    bit ph;
    guard = 0;
    while (!bus.rd_req_ready_o) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin fail_msg("req_ready_timeout"); return; end
    end
    bus.rd_req_v_i = 1'b1;
    bus.rd_row_i   = RW'(row);
    bus.rd_col_i   = CW'(col);
    @(posedge clk); #1;
    bus.rd_req_v_i = 1'b0;
    guard = 0;
    ph    = 1'b1;
    while (tile_beats < NB) begin
      bus.rd_yumi_i = bus.rd_v_o & (alt ? ph : 1'b1);
      bus.release_i = (guard == rel_at);
      @(posedge clk); #1;
      ph = ~ph;
      guard++;
      if (guard > 200) begin fail_msg("tile_timeout"); break; end
    end
    bus.rd_yumi_i = 1'b0;
    bus.release_i = 1'b0;
    chk("tile_beat_count", wide_t'(tile_beats), wide_t'(NB));
  endtask

  initial begin
    int guard;
    bus.wr_v_i = 1'b0; bus.wr_data_i = '0;
    bus.rd_req_v_i = 1'b0; bus.rd_row_i = '0; bus.rd_col_i = '0;
    bus.rd_yumi_i = 1'b0; bus.release_i = 1'b0;
    tile_beats = 0;
    fork
      monitor();
      begin
        #500000;
        fail_msg("global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // load and fill
    load_bank(0);
    chk("fill1_bank_full", wide_t'(bus.bank_full_o), wide_t'(2'b01));
    chk("fill1_wr_ready",  wide_t'(bus.wr_ready_o), wide_t'(1));
    load_bank(1024);
    chk("fill2_bank_full", wide_t'(bus.bank_full_o), wide_t'(2'b11));
    chk("fill2_wr_ready",  wide_t'(bus.wr_ready_o), '0);
    bus.wr_v_i = 1'b1; bus.wr_data_i = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 bus.wr_v_i = 1'b0;
    chk("overfill_bank_full", wide_t'(bus.bank_full_o), wide_t'(2'b11));

    // interior tile
    run_tile(0, 0, 1'b0, -1);
    chk("int_b0_l0",  wide_t'(cap[0][0 +: W]), '0);
    chk("int_b5_l2",  wide_t'(cap[5][2*W +: W]), wide_t'(529));
    chk("int_b15_l3", wide_t'(cap[15][3*W +: W]), wide_t'(819));

    // edge tile
    run_tile(14, 14, 1'b0, -1);
    chk("edge_b0_l1",  wide_t'(cap[0][W +: W]), wide_t'(494));
    chk("edge_b5_l0",  wide_t'(cap[5][0 +: W]), wide_t'(255));
    chk("edge_b2_pad", cap[2], '0);
    chk("edge_b10_pad", cap[10], '0);

    // backpressure tile
    run_tile(4, 8, 1'b1, -1);
    chk("bp_b0_l3",  wide_t'(cap[0][3*W +: W]), wide_t'(840));
    chk("bp_b15_l0", wide_t'(cap[15][0 +: W]), wide_t'(123));

    // release during RUN is ignored
    run_tile(0, 0, 1'b0, 3);
    chk("run_release_full", wide_t'(bus.bank_full_o), wide_t'(2'b11));

    // release in IDLE
    bus.release_i = 1'b1;
    @(posedge clk); #1;
    bus.release_i = 1'b0;
    chk("idle_release_full",  wide_t'(bus.bank_full_o), wide_t'(2'b10));
    chk("idle_release_ready", wide_t'(bus.wr_ready_o), wide_t'(1));

    run_tile(0, 0, 1'b0, -1);
    chk("bank1_b0_l0", wide_t'(cap[0][0 +: W]), wide_t'(1024));
    chk("bank1_b5_l1", wide_t'(cap[5][W +: W]), wide_t'(1297));

    // async reset during beat 5
    bus.rd_req_v_i = 1'b1; bus.rd_row_i = RW'(2); bus.rd_col_i = CW'(2);
    @(posedge clk); #1;
    bus.rd_req_v_i = 1'b0;
    guard = 0;
    while (!(bus.rd_v_o && tile_beats == 4)) begin
      bus.rd_yumi_i = bus.rd_v_o;
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin fail_msg("beat5_timeout"); break; end
    end
    bus.rd_yumi_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_v",      wide_t'(bus.rd_v_o), '0);
    chk("async_bank_full", wide_t'(bus.bank_full_o), '0);
    chk("async_rd_data",   bus.rd_data_o, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", wide_t'(bus.rd_req_ready_o), '0);
    chk("post_rst_wr_ready",  wide_t'(bus.wr_ready_o), wide_t'(1));
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
